// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, arbiter FSM state and arbiter defaults.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RETRY, RESP} arbstate_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int MAX_RETRY_DEF  = 3;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals.
interface mem_arbiter_if import cpu_types_pkg::*; #(
  parameter int WORD_W = 32
) (
  input logic CLK
);
  logic              nRST;
  logic              iREN, dREN, dWEN;
  logic              iwait, dwait, fault;
  logic              ramREN, ramWEN;
  logic [WORD_W-1:0] iaddr, iload, daddr, dstore, dload;
  logic [WORD_W-1:0] ramaddr, ramstore, ramload;
  ramstate_t         ramstate;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault
  );
  modport tb (
    input  CLK, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );
endinterface

// File: rtl/mem_arb_picker.sv
// Grant selection for IDLE: data first, unless fetch has waited STARVE_MAX data grants.
module mem_arb_picker import cpu_types_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_idle,
  input  logic i_iren,
  input  logic i_dren,
  input  logic i_dwen,
  output logic o_pick_d,
  output logic o_pick_i
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_force_i;

  assign w_force_i = i_iren && (r_starve_cnt == CW'(STARVE_MAX));
  assign o_pick_d  = (i_dren || i_dwen) && !w_force_i;
  assign o_pick_i  = !o_pick_d && i_iren;

  // Counter only moves on an actual grant; it saturates naturally since a full count forces fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= '0;
    end else if (i_idle) begin
      if (o_pick_d)      r_starve_cnt <= i_iren ? r_starve_cnt + 1'b1 : '0;
      else if (o_pick_i) r_starve_cnt <= '0;
    end
  end
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Registered fetch/data arbiter in front of the single-ported RAM, with bounded ERROR retry.
module mem_arbiter_ctrl import cpu_types_pkg::*; #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              fault
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  arbstate_t         r_state, w_next;
  logic              w_pick_d, w_pick_i, w_can_retry;
  logic              r_gnt_i, r_wr;
  logic [WORD_W-1:0] r_addr, r_store;
  logic [RW-1:0]     r_retry;

  mem_arb_picker #(.STARVE_MAX(STARVE_MAX)) u_picker (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_idle  (r_state == IDLE),
    .i_iren  (iREN),
    .i_dren  (dREN),
    .i_dwen  (dWEN),
    .o_pick_d(w_pick_d),
    .o_pick_i(w_pick_i)
  );

  assign w_can_retry = r_retry < RW'(MAX_RETRY);
  assign ramaddr     = r_addr;
  assign ramstore    = r_store;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d)      w_next = GRANT_D;
        else if (w_pick_i) w_next = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (ramstate == ACCESS)     w_next = RESP;
        else if (ramstate == ERROR) w_next = w_can_retry ? RETRY : RESP;
      end
      RETRY:   w_next = r_gnt_i ? GRANT_I : GRANT_D;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    iwait  = 1'b1;
    dwait  = 1'b1;
    case (r_state)
      GRANT_I: ramREN = 1'b1;
      GRANT_D: begin
        ramREN = !r_wr;
        ramWEN = r_wr;
      end
      RESP: begin
        if (r_gnt_i) iwait = 1'b0;
        else         dwait = 1'b0;
      end
      default: ;
    endcase
  end

  // Operand latch, load capture, retry budget and sticky fault.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_gnt_i <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
      r_retry <= '0;
      iload   <= '0;
      dload   <= '0;
      fault   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_gnt_i <= 1'b0;
            r_wr    <= dWEN;
            r_addr  <= daddr;
            r_store <= dstore;
          end else if (w_pick_i) begin
            r_gnt_i <= 1'b1;
            r_wr    <= 1'b0;
            r_addr  <= iaddr;
          end
        end
        GRANT_I, GRANT_D: begin
          if (ramstate == ACCESS) begin
            r_retry <= '0;
            if (!r_wr) begin
              if (r_gnt_i) iload <= ramload;
              else         dload <= ramload;
            end
          end else if (ramstate == ERROR) begin
            if (w_can_retry) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_retry <= '0;
              fault   <= 1'b1;
              if (r_gnt_i) iload <= '0;
              else         dload <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: grant order, RAM wait/error handling and async reset.
module tb_mem_arbiter_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.WORD_W(32)) bus (.CLK(CLK));

  mem_arbiter_ctrl #(.WORD_W(32), .STARVE_MAX(4), .MAX_RETRY(3)) dut (
    .CLK     (CLK),
    .nRST    (bus.nRST),
    .iREN    (bus.iREN),
    .iaddr   (bus.iaddr),
    .iwait   (bus.iwait),
    .iload   (bus.iload),
    .dREN    (bus.dREN),
    .dWEN    (bus.dWEN),
    .daddr   (bus.daddr),
    .dstore  (bus.dstore),
    .dwait   (bus.dwait),
    .dload   (bus.dload),
    .ramREN  (bus.ramREN),
    .ramWEN  (bus.ramWEN),
    .ramaddr (bus.ramaddr),
    .ramstore(bus.ramstore),
    .ramload (bus.ramload),
    .ramstate(bus.ramstate),
    .fault   (bus.fault)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    string order;
    string exp_order;
    int    lows;
    logic [31:0] load_at_resp;
    logic        fault_at_resp;

    bus.nRST = 1'b0;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
    bus.ramstate = FREE;
    tick(); tick();
    chk("rst_iwait",  bus.iwait, 1);
    chk("rst_dwait",  bus.dwait, 1);
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramWEN", bus.ramWEN, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_iload",  bus.iload, 0);
    chk("rst_dload",  bus.dload, 0);
    chk("rst_fault",  bus.fault, 0);
    bus.nRST = 1'b1;
    tick();

    // Fetch only, RAM ready on first grant cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
    tick();
    chk("f_ramREN", bus.ramREN, 1);
    chk("f_ramaddr", bus.ramaddr, 32'h40);
    chk("f_iwait_c1", bus.iwait, 1);
    bus.iREN = 1'b0;
    tick();
    chk("f_iwait_c2", bus.iwait, 0);
    chk("f_iload", bus.iload, 32'h8C220004);
    chk("f_dwait_c2", bus.dwait, 1);
    chk("f_ramREN_resp", bus.ramREN, 0);
    tick();
    chk("f_iwait_c3", bus.iwait, 1);

    // Simultaneous fetch + store: store first, fetch on next IDLE
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    tick();
    chk("s_ramWEN", bus.ramWEN, 1);
    chk("s_ramREN", bus.ramREN, 0);
    chk("s_ramaddr", bus.ramaddr, 32'h100);
    chk("s_ramstore", bus.ramstore, 32'hDEADBEEF);
    bus.dWEN = 1'b0;
    tick();
    chk("s_dwait", bus.dwait, 0);
    chk("s_iwait", bus.iwait, 1);
    tick();
    chk("s_idle_ramREN", bus.ramREN, 0);
    tick();
    chk("s_fetch_ramREN", bus.ramREN, 1);
    chk("s_fetch_addr", bus.ramaddr, 32'h44);
    bus.iREN = 1'b0;
    tick();
    chk("s_fetch_iwait", bus.iwait, 0);
    tick();

    // Starvation guard
    bus.dREN = 1'b1; bus.iREN = 1'b1; bus.daddr = 32'h200; bus.iaddr = 32'h300;
    bus.ramload = 32'h11111111;
    order = "";
    for (int k = 0; k < 10; k++) begin
      tick();
      order = {order, (bus.ramaddr == 32'h300) ? "I" : "D"};
      tick();
      tick();
    end
    bus.dREN = 1'b0; bus.iREN = 1'b0;
    exp_order = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) chk($sformatf("starve_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    chk("starve_dload", bus.dload, 32'h11111111);

    // RAM BUSY for 5 cycles, changing requester inputs ignored
    bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY; bus.ramload = 32'hCAFEF00D;
    tick();
    bus.dREN = 1'b0; bus.daddr = 32'hFFF;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("busy_ren_%0d", k), bus.ramREN, 1);
      chk($sformatf("busy_addr_%0d", k), bus.ramaddr, 32'h400);
      chk($sformatf("busy_dwait_%0d", k), bus.dwait, 1);
      tick();
    end
    bus.ramstate = ACCESS;
    chk("busy_ren_last", bus.ramREN, 1);
    tick();
    chk("busy_dwait_resp", bus.dwait, 0);
    chk("busy_dload", bus.dload, 32'hCAFEF00D);
    tick();
    chk("busy_dwait_after", bus.dwait, 1);

    // ERROR twice, then ACCESS
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = ERROR; bus.ramload = 32'h12345678;
    tick();
    bus.dREN = 1'b0;
    chk("e2_g1_ren", bus.ramREN, 1);
    tick();
    chk("e2_gap1_ren", bus.ramREN, 0);
    chk("e2_gap1_dwait", bus.dwait, 1);
    tick();
    chk("e2_g2_ren", bus.ramREN, 1);
    chk("e2_g2_addr", bus.ramaddr, 32'h500);
    tick();
    chk("e2_gap2_ren", bus.ramREN, 0);
    bus.ramstate = ACCESS;
    tick();
    chk("e2_g3_ren", bus.ramREN, 1);
    tick();
    chk("e2_dwait", bus.dwait, 0);
    chk("e2_dload", bus.dload, 32'h12345678);
    chk("e2_fault", bus.fault, 0);
    tick();

    // ERROR four times: budget exhausted
    bus.dREN = 1'b1; bus.daddr = 32'h600; bus.ramstate = ERROR; bus.ramload = 32'h9999AAAA;
    tick();
    bus.dREN = 1'b0;
    lows = 0; load_at_resp = 32'hFFFFFFFF; fault_at_resp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.dwait == 1'b0) begin
        lows++;
        load_at_resp = bus.dload;
        fault_at_resp = bus.fault;
      end
    end
    chk("e4_pulses", lows, 1);
    chk("e4_dload", load_at_resp, 0);
    chk("e4_fault_resp", fault_at_resp, 1);
    chk("e4_fault_after", bus.fault, 1);

    // A clean access afterwards leaves fault set
    bus.dREN = 1'b1; bus.daddr = 32'h700; bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D;
    tick();
    bus.dREN = 1'b0;
    tick();
    chk("sticky_dwait", bus.dwait, 0);
    chk("sticky_dload", bus.dload, 32'h0BADF00D);
    chk("sticky_fault", bus.fault, 1);
    tick();

    // Reset in the middle of a stalled store
    bus.dWEN = 1'b1; bus.daddr = 32'h800; bus.dstore = 32'hA5A5A5A5; bus.ramstate = BUSY;
    tick();
    chk("r_ramWEN_pre", bus.ramWEN, 1);
    bus.dWEN = 1'b0;
    #2 bus.nRST = 1'b0;
    #1;
    chk("r_ramWEN_async", bus.ramWEN, 0);
    chk("r_dwait_async", bus.dwait, 1);
    chk("r_ramaddr_async", bus.ramaddr, 0);
    chk("r_fault_async", bus.fault, 0);
    @(posedge CLK);
    #1 bus.nRST = 1'b1;
    bus.ramstate = ACCESS;
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.dwait == 1'b0 || bus.ramWEN == 1'b1) lows++;
    end
    chk("r_no_completion", lows, 0);
    bus.iREN = 1'b1; bus.iaddr = 32'h900;
    tick();
    chk("r_idle_grant_ren", bus.ramREN, 1);
    chk("r_idle_grant_addr", bus.ramaddr, 32'h900);
    bus.iREN = 1'b0;
    tick();
    chk("r_idle_iwait", bus.iwait, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
